voice_sweeper: RTL and testbench

- Control-side driver for the per-channel phase accumulator bank; it produces acc_en, acc_clr, curr_note and phi_in, and reads back the selected phase.
- Accepts note-on/note-off events and allocates them to NUM_CHANNELS voices, storing one tuning word per voice.
- On each sample tick it sweeps every channel once: it advances the active accumulators and streams the pre-advance phases toward the waveform LUT.

---
 rtl/voice_sweeper.sv | 191 +++++++++++++++++++
 tb/tb_voice_sweeper.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_sweeper.sv
// Voice allocator and per-sample channel sweeper for a phase-accumulator bank.
// Note events claim voices; each sample tick walks every channel once and forwards pre-advance phases.
module voice_sweeper #(
    parameter int NUM_BITS     = 32,
    parameter int NUM_CHANNELS = 16,
    parameter int NOTE_BITS    = 7,
    localparam int CHAN_BITS   = $clog2(NUM_CHANNELS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sample_tick,
    input  logic                    note_valid,
    output logic                    note_ready,
    input  logic                    note_on,
    input  logic [NOTE_BITS-1:0]    note_num,
    input  logic [NUM_BITS-1:0]     note_inc,
    output logic [NUM_CHANNELS-1:0] acc_en,
    output logic [NUM_CHANNELS-1:0] acc_clr,
    output logic [NUM_CHANNELS-1:0] curr_note,
    output logic [NUM_BITS-1:0]     phi_in,
    input  logic [NUM_BITS-1:0]     phi_rd,
    output logic [NUM_BITS-1:0]     lut_phase,
    output logic [CHAN_BITS-1:0]    lut_chan,
    output logic                    lut_valid,
    output logic                    sweep_done,
    output logic [NUM_CHANNELS-1:0] voice_active,
    output logic                    drop_pulse,
    output logic                    overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVENT = 2'd1,
        SWEEP = 2'd2
    } state_t;

    localparam logic [CHAN_BITS-1:0] LAST_CHAN = CHAN_BITS'(NUM_CHANNELS - 1);

    state_t                  state_q, state_d;
    logic [CHAN_BITS-1:0]    k_q, k_d;
    logic [NUM_CHANNELS-1:0] active_q;
    logic [NOTE_BITS-1:0]    note_q [NUM_CHANNELS];
    logic [NUM_BITS-1:0]     inc_q  [NUM_CHANNELS];

    // Event fields captured at the handshake, consumed in the EVENT cycle.
    logic                    ev_on_q;
    logic [NOTE_BITS-1:0]    ev_num_q;
    logic [NUM_BITS-1:0]     ev_inc_q;

    logic                    hit;
    logic [CHAN_BITS-1:0]    hit_idx;
    logic                    free;
    logic [CHAN_BITS-1:0]    free_idx;

    assign voice_active = active_q;

    // Lowest-index active voice holding the event note, and lowest-index idle voice.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free     = 1'b0;
        free_idx = '0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (active_q[i] && (note_q[i] == ev_num_q)) begin
                hit     = 1'b1;
                hit_idx = CHAN_BITS'(i);
            end
            if (!active_q[i]) begin
                free     = 1'b1;
                free_idx = CHAN_BITS'(i);
            end
        end
    end

    always_comb begin
        // NOTE: every output and next-state value gets a default first so no path infers a latch.
        state_d    = state_q;
        k_d        = k_q;
        note_ready = 1'b0;
        acc_en     = '0;
        acc_clr    = '0;
        curr_note  = '0;
        phi_in     = '0;
        drop_pulse = 1'b0;
        overrun    = 1'b0;

        unique case (state_q)
            IDLE: begin
                note_ready = !sample_tick;
                if (sample_tick) begin
                    state_d = SWEEP;
                    k_d     = '0;
                end else if (note_valid) begin
                    state_d = EVENT;
                end
            end
            EVENT: begin
                overrun = sample_tick;
                state_d = IDLE;
                if (ev_on_q) begin
                    if (hit) begin
                        acc_clr[hit_idx] = 1'b1;
                    end else if (free) begin
                        acc_clr[free_idx] = 1'b1;
                    end else begin
                        drop_pulse = 1'b1;
                    end
                end
            end
            SWEEP: begin
                overrun        = sample_tick;
                curr_note[k_q] = 1'b1;
                if (active_q[k_q]) begin
                    acc_en[k_q] = 1'b1;
                    phi_in      = inc_q[k_q];
                end
                if (k_q == LAST_CHAN) begin
                    state_d = IDLE;
                    k_d     = '0;
                end else begin
                    k_d = k_q + CHAN_BITS'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Reset silences every strobe in the reset cycle itself, even mid-sweep.
        if (rst) begin
            note_ready = 1'b0;
            acc_en     = '0;
            acc_clr    = '0;
            curr_note  = '0;
            phi_in     = '0;
            drop_pulse = 1'b0;
            overrun    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            k_q        <= '0;
            active_q   <= '0;
            ev_on_q    <= 1'b0;
            ev_num_q   <= '0;
            ev_inc_q   <= '0;
            lut_phase  <= '0;
            lut_chan   <= '0;
            lut_valid  <= 1'b0;
            sweep_done <= 1'b0;
            // NOTE: the voice table is small and must come back empty, so it is reset like any register.
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                note_q[i] <= '0;
                inc_q[i]  <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments keep every register update based on pre-edge values.
            state_q <= state_d;
            k_q     <= k_d;

            if (state_q == IDLE && note_valid && note_ready) begin
                ev_on_q  <= note_on;
                ev_num_q <= note_num;
                ev_inc_q <= note_inc;
            end

            if (state_q == EVENT) begin
                if (ev_on_q) begin
                    if (hit) begin
                        inc_q[hit_idx] <= ev_inc_q;
                    end else if (free) begin
                        active_q[free_idx] <= 1'b1;
                        note_q[free_idx]   <= ev_num_q;
                        inc_q[free_idx]    <= ev_inc_q;
                    end
                end else if (hit) begin
                    active_q[hit_idx] <= 1'b0;
                end
            end

            // One-cycle pipeline from the accumulator read port to the LUT.
            lut_valid  <= (state_q == SWEEP) && active_q[k_q];
            sweep_done <= (state_q == SWEEP) && (k_q == LAST_CHAN);
            if (state_q == SWEEP) begin
                lut_phase <= phi_rd;
                lut_chan  <= k_q;
            end
        end
    end

endmodule

// File: tb/tb_voice_sweeper.sv
// Self-checking bench for voice_sweeper: table-driven event vectors, directed sweep corners,
// and random traffic against a voice-level reference model with an accumulator bank model.
module tb_voice_sweeper;

    localparam int NB = 32;
    localparam int NC = 16;
    localparam int NT = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          sample_tick;
    logic          note_valid;
    logic          note_ready;
    logic          note_on;
    logic [NT-1:0] note_num;
    logic [NB-1:0] note_inc;
    logic [NC-1:0] acc_en;
    logic [NC-1:0] acc_clr;
    logic [NC-1:0] curr_note;
    logic [NB-1:0] phi_in;
    logic [NB-1:0] phi_rd;
    logic [NB-1:0] lut_phase;
    logic [3:0]    lut_chan;
    logic          lut_valid;
    logic          sweep_done;
    logic [NC-1:0] voice_active;
    logic          drop_pulse;
    logic          overrun;

    always #5 clk = ~clk;

    voice_sweeper dut (
        .clk(clk), .rst(rst), .sample_tick(sample_tick),
        .note_valid(note_valid), .note_ready(note_ready), .note_on(note_on),
        .note_num(note_num), .note_inc(note_inc),
        .acc_en(acc_en), .acc_clr(acc_clr), .curr_note(curr_note),
        .phi_in(phi_in), .phi_rd(phi_rd),
        .lut_phase(lut_phase), .lut_chan(lut_chan), .lut_valid(lut_valid),
        .sweep_done(sweep_done), .voice_active(voice_active),
        .drop_pulse(drop_pulse), .overrun(overrun)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Environment: the accumulator bank the block drives (cleared with the system reset).
    logic [NB-1:0] bank [NC];
    always_ff @(posedge clk) begin
        for (int i = 0; i < NC; i++) begin
            if (rst || acc_clr[i]) bank[i] <= '0;
            else if (acc_en[i])    bank[i] <= bank[i] + phi_in;
        end
    end
    always_comb begin
        phi_rd = '0;
        for (int i = 0; i < NC; i++) if (curr_note[i]) phi_rd = bank[i];
    end

    // Reference model: voices as plain records plus each voice's expected phase.
    bit            m_act   [NC];
    logic [NT-1:0] m_note  [NC];
    logic [NB-1:0] m_inc   [NC];
    logic [NB-1:0] m_phase [NC];
    logic [NB-1:0] ch0_seen;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NC-1:0] pack_act();
        logic [NC-1:0] r = '0;
        for (int i = 0; i < NC; i++) r[i] = m_act[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NC; i++) begin
            m_act[i] = 0; m_note[i] = '0; m_inc[i] = '0; m_phase[i] = '0;
        end
    endtask

    task automatic model_event(input bit on, input logic [NT-1:0] num, input logic [NB-1:0] inc,
                               output logic [NC-1:0] clr, output bit drop);
        int h = -1;
        int f = -1;
        for (int i = 0; i < NC; i++) begin
            if (h < 0 && m_act[i] && m_note[i] == num) h = i;
            if (f < 0 && !m_act[i]) f = i;
        end
        clr = '0;
        drop = 0;
        if (on) begin
            if (h >= 0) begin
                clr[h] = 1'b1; m_inc[h] = inc; m_phase[h] = '0;
            end else if (f >= 0) begin
                clr[f] = 1'b1; m_act[f] = 1; m_note[f] = num; m_inc[f] = inc; m_phase[f] = '0;
            end else begin
                drop = 1;
            end
        end else if (h >= 0) begin
            m_act[h] = 0;
        end
    endtask

    // Called right after the handshake edge: the DUT is in its event cycle.
    task automatic ev_cycle(input bit on, input logic [NT-1:0] num, input logic [NB-1:0] inc,
                            output logic [NC-1:0] got_clr, output bit got_drop,
                            output logic [NC-1:0] got_act);
        logic [NC-1:0] eclr;
        bit edrop;
        note_valid = 1'b0;
        model_event(on, num, inc, eclr, edrop);
        @(negedge clk);
        check("ev_acc_clr", acc_clr, eclr);
        check("ev_drop", drop_pulse, edrop);
        check("ev_ready", note_ready, 0);
        check("ev_acc_en", acc_en, 0);
        got_clr  = acc_clr;
        got_drop = drop_pulse;
        step();
        @(negedge clk);
        check("ev_active", voice_active, pack_act());
        got_act = voice_active;
        step();
    endtask

    task automatic send_event(input bit on, input logic [NT-1:0] num, input logic [NB-1:0] inc,
                              output logic [NC-1:0] got_clr, output bit got_drop,
                              output logic [NC-1:0] got_act);
        bit ok = 0;
        note_valid = 1'b1; note_on = on; note_num = num; note_inc = inc;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            if (note_ready) begin
                ok = 1;
                break;
            end
            step();
        end
        if (!ok) begin
            n_checks++; n_err++;
            $display("FAIL accept_timeout: note_ready never rose for note %0d", num);
            note_valid = 1'b0;
            got_clr = '0; got_drop = 0; got_act = '0;
        end else begin
            step();
            ev_cycle(on, num, inc, got_clr, got_drop, got_act);
        end
    endtask

    // Tick, then check every sweep cycle and the trailing LUT cycle.
    // ovr_at: channel at which a stray tick is injected; abort_at: channel at which rst is pulsed.
    task automatic do_sweep(input int ovr_at, input int abort_at, input bit ev_pending);
        logic [NB-1:0] prev_phase = '0;
        bit            prev_valid = 0;
        sample_tick = 1'b1;
        @(negedge clk);
        check("tick_ready", note_ready, 0);
        check("tick_overrun", overrun, 0);
        step();
        sample_tick = 1'b0;
        for (int k = 0; k < NC; k++) begin
            if (k == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                check("rst_curr_note", curr_note, 0);
                check("rst_acc_en", acc_en, 0);
                check("rst_ready", note_ready, 0);
                step();
                rst = 1'b0;
                model_reset();
                @(negedge clk);
                check("post_rst_acc_en", acc_en, 0);
                check("post_rst_acc_clr", acc_clr, 0);
                check("post_rst_curr_note", curr_note, 0);
                check("post_rst_active", voice_active, 0);
                check("post_rst_lut_valid", lut_valid, 0);
                check("post_rst_done", sweep_done, 0);
                step();
                return;
            end
            sample_tick = (k == ovr_at);
            @(negedge clk);
            check("sw_curr_note", curr_note, 16'h1 << k);
            check("sw_acc_en", acc_en, m_act[k] ? (16'h1 << k) : 16'h0);
            check("sw_phi_in", phi_in, m_act[k] ? m_inc[k] : '0);
            check("sw_acc_clr", acc_clr, 0);
            check("sw_ready", note_ready, 0);
            check("sw_overrun", overrun, k == ovr_at);
            check("sw_done", sweep_done, 0);
            if (k == 0) begin
                check("sw_lut_valid0", lut_valid, 0);
            end else begin
                check("sw_lut_valid", lut_valid, prev_valid);
                check("sw_lut_chan", lut_chan, k - 1);
                check("sw_lut_phase", lut_phase, prev_phase);
                if (k == 1) ch0_seen = lut_phase;
            end
            prev_phase = m_phase[k];
            prev_valid = m_act[k];
            if (m_act[k]) m_phase[k] = m_phase[k] + m_inc[k];
            step();
            sample_tick = 1'b0;
        end
        @(negedge clk);
        check("tail_lut_valid", lut_valid, prev_valid);
        check("tail_lut_chan", lut_chan, NC - 1);
        check("tail_lut_phase", lut_phase, prev_phase);
        check("tail_done", sweep_done, 1);
        check("tail_curr_note", curr_note, 0);
        check("tail_ready", note_ready, 1);
        step();
        if (!ev_pending) begin
            @(negedge clk);
            check("after_lut_valid", lut_valid, 0);
            check("after_done", sweep_done, 0);
            step();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; note_valid = 1'b0; sample_tick = 1'b0;
        step();
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit            on;
        logic [NT-1:0] num;
        logic [NB-1:0] inc;
        logic [NC-1:0] exp_clr;
        bit            exp_drop;
        logic [NC-1:0] exp_act;
    } ev_vec_t;

    ev_vec_t vec [8];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NC-1:0] gclr, gact;
        bit gdrop;

        vec[0] = '{1, 7'd60, 32'h0010_0000, 16'h0001, 0, 16'h0001};
        vec[1] = '{1, 7'd62, 32'h0020_0000, 16'h0002, 0, 16'h0003};
        vec[2] = '{1, 7'd64, 32'h0030_0000, 16'h0004, 0, 16'h0007};
        vec[3] = '{0, 7'd62, 32'h0000_0000, 16'h0000, 0, 16'h0005};
        vec[4] = '{1, 7'd65, 32'h0040_0000, 16'h0002, 0, 16'h0007};
        vec[5] = '{1, 7'd64, 32'h0050_0000, 16'h0004, 0, 16'h0007};
        vec[6] = '{0, 7'd99, 32'h0000_0000, 16'h0000, 0, 16'h0007};
        vec[7] = '{0, 7'd60, 32'h0000_0000, 16'h0000, 0, 16'h0006};

        rst = 1'b1; sample_tick = 1'b0; note_valid = 1'b0;
        note_on = 1'b0; note_num = '0; note_inc = '0;
        model_reset();
        step();
        step();
        @(negedge clk);
        check("reset_ready", note_ready, 0);
        check("reset_active", voice_active, 0);
        check("reset_lut_valid", lut_valid, 0);
        check("reset_done", sweep_done, 0);
        check("reset_curr_note", curr_note, 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", note_ready, 1);
        step();

        // Empty sweep: walking select, no enables, a single sweep_done.
        do_sweep(-1, -1, 0);

        // One voice advancing across three sweeps.
        do_reset();
        send_event(1, 7'd60, 32'h0100_0000, gclr, gdrop, gact);
        check("first_clr", gclr, 16'h0001);
        do_sweep(-1, -1, 0);
        check("ch0_sweep1", ch0_seen, 32'h0000_0000);
        do_sweep(-1, -1, 0);
        check("ch0_sweep2", ch0_seen, 32'h0100_0000);
        do_sweep(-1, -1, 0);
        check("ch0_sweep3", ch0_seen, 32'h0200_0000);

        // Allocation / release / retrigger table.
        do_reset();
        foreach (vec[i]) begin
            send_event(vec[i].on, vec[i].num, vec[i].inc, gclr, gdrop, gact);
            check("vec_clr", gclr, vec[i].exp_clr);
            check("vec_drop", gdrop, vec[i].exp_drop);
            check("vec_active", gact, vec[i].exp_act);
        end
        do_sweep(-1, -1, 0);

        // Fill every voice, overflow once, then retrigger a held note.
        do_reset();
        for (int i = 0; i < NC; i++) send_event(1, 7'(i), 32'(i * 32'h1000 + 1), gclr, gdrop, gact);
        check("full_map", gact, 16'hFFFF);
        send_event(1, 7'd100, 32'h1234, gclr, gdrop, gact);
        check("full_drop", gdrop, 1);
        check("full_no_clr", gclr, 16'h0000);
        do_sweep(9, -1, 0);
        send_event(1, 7'd5, 32'h0ABC_0000, gclr, gdrop, gact);
        check("retrig_clr", gclr, 16'h0020);
        check("retrig_map", gact, 16'hFFFF);
        do_sweep(-1, -1, 0);

        // Event offered together with a tick waits for the sweep to end.
        note_valid = 1'b1; note_on = 1'b0; note_num = 7'd3; note_inc = '0;
        do_sweep(-1, -1, 1);
        ev_cycle(0, 7'd3, '0, gclr, gdrop, gact);
        check("deferred_off_map", gact, 16'hFFF7);

        // Reset in the middle of a sweep, then a clean sweep.
        do_sweep(-1, 7, 0);
        do_sweep(-1, -1, 0);

        // Random traffic.
        for (int it = 0; it < 150; it++) begin
            int r = $urandom_range(0, 9);
            bit on = ($urandom_range(0, 2) != 0);
            logic [NT-1:0] num = 7'(60 + $urandom_range(0, 19));
            logic [NB-1:0] inc = $urandom;
            if (r < 6) begin
                send_event(on, num, inc, gclr, gdrop, gact);
            end else if (r < 9) begin
                do_sweep(($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : -1, -1, 0);
            end else begin
                note_valid = 1'b1; note_on = on; note_num = num; note_inc = inc;
                do_sweep(-1, -1, 1);
                ev_cycle(on, num, inc, gclr, gdrop, gact);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

    // Strobe exclusivity holds in every cycle.
    always @(negedge clk) begin
        if (!rst) begin
            check("acc_en_single", $countones(acc_en) <= 1, 1);
            check("acc_clr_single", $countones(acc_clr) <= 1, 1);
            check("en_clr_disjoint", (acc_en != 0) && (acc_clr != 0), 0);
        end
    end

endmodule
